// File: rtl/peripheral_msi_data_resize_seq_wb.sv
// Sequential Wishbone downsizer: splits one wide master access into ascending
// narrow slave accesses (one per byte-lane group with any select set) and reassembles read data.
module peripheral_msi_data_resize_seq_wb #(
  parameter int AW  = 32,
  parameter int MDW = 32,
  parameter int SDW = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [AW-1:0]        wbm_adr_i,
  input  logic [MDW-1:0]       wbm_dat_i,
  input  logic [MDW/8-1:0]     wbm_sel_i,
  input  logic                 wbm_we_i,
  input  logic                 wbm_cyc_i,
  input  logic                 wbm_stb_i,
  input  logic [2:0]           wbm_cti_i,
  input  logic [1:0]           wbm_bte_i,
  output logic [MDW-1:0]       wbm_dat_o,
  output logic                 wbm_ack_o,
  output logic                 wbm_err_o,
  output logic                 wbm_rty_o,
  output logic [AW-1:0]        wbs_adr_o,
  output logic [SDW-1:0]       wbs_dat_o,
  output logic [SDW/8-1:0]     wbs_sel_o,
  output logic                 wbs_we_o,
  output logic                 wbs_cyc_o,
  output logic                 wbs_stb_o,
  output logic [2:0]           wbs_cti_o,
  output logic [1:0]           wbs_bte_o,
  input  logic [SDW-1:0]       wbs_dat_i,
  input  logic                 wbs_ack_i,
  input  logic                 wbs_err_i,
  input  logic                 wbs_rty_i
);
  localparam int R   = MDW / SDW;
  localparam int MSW = MDW / 8;
  localparam int SSW = SDW / 8;
  localparam int SB  = $clog2(SSW);
  localparam int LW  = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAIL} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [MDW-1:0]    dat_q, dat_d;
  logic [MSW-1:0]    sel_q, sel_d;
  logic              we_q, we_d;
  logic [R-1:0]      mask_q, mask_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [MDW-1:0]    rdat_q, rdat_d;
  logic              ack_q, ack_d, err_q, err_d, rty_q, rty_d;
  logic              s_cyc_q, s_cyc_d, s_we_q, s_we_d;
  logic [AW-1:0]     s_adr_q, s_adr_d;
  logic [SDW-1:0]    s_dat_q, s_dat_d;
  logic [SSW-1:0]    s_sel_q, s_sel_d;

  // cycle/burst type are accepted but every beat is treated as classic
  logic unused_cti_bte;
  assign unused_cti_bte = ^{wbm_cti_i, wbm_bte_i};

  function automatic logic [LW-1:0] first_set(input logic [R-1:0] m);
    first_set = '0;
    for (int i = R - 1; i >= 0; i--)
      if (m[i]) first_set = LW'(i);
  endfunction

  logic [R-1:0] req_mask, rem_mask;
  always_comb begin
    req_mask = '0;
    for (int i = 0; i < R; i++)
      req_mask[i] = |wbm_sel_i[i*SSW +: SSW];
  end

  logic              ld;
  logic [LW-1:0]     ld_lane;
  logic [AW-1:0]     src_adr;
  logic [MDW-1:0]    src_dat;
  logic [MSW-1:0]    src_sel;

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    mask_d   = mask_q;
    lane_d   = lane_q;
    rdat_d   = rdat_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rty_d    = 1'b0;
    s_cyc_d  = s_cyc_q;
    s_we_d   = s_we_q;
    s_adr_d  = s_adr_q;
    s_dat_d  = s_dat_q;
    s_sel_d  = s_sel_q;
    ld       = 1'b0;
    ld_lane  = '0;
    src_adr  = adr_q;
    src_dat  = dat_q;
    src_sel  = sel_q;
    rem_mask = mask_q & ~(R'(1) << lane_q);

    case (state_q)
      IDLE: if (wbm_cyc_i && wbm_stb_i) begin
        adr_d  = wbm_adr_i;
        dat_d  = wbm_dat_i;
        sel_d  = wbm_sel_i;
        we_d   = wbm_we_i;
        rdat_d = '0;
        mask_d = req_mask;
        if (req_mask == '0) begin
          ack_d   = 1'b1;
          state_d = DONE;
        end else begin
          // first lane is driven straight from the inputs so strobe rises next cycle
          ld      = 1'b1;
          ld_lane = first_set(req_mask);
          src_adr = wbm_adr_i;
          src_dat = wbm_dat_i;
          src_sel = wbm_sel_i;
          s_we_d  = wbm_we_i;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!wbm_cyc_i) begin
          s_cyc_d = 1'b0;
          state_d = IDLE;
        end else if (wbs_err_i) begin
          s_cyc_d = 1'b0;
          err_d   = 1'b1;
          state_d = FAIL;
        end else if (wbs_rty_i) begin
          s_cyc_d = 1'b0;
          rty_d   = 1'b1;
          state_d = FAIL;
        end else if (wbs_ack_i) begin
          if (!we_q) rdat_d[lane_q*SDW +: SDW] = wbs_dat_i;
          mask_d = rem_mask;
          if (rem_mask != '0) begin
            ld      = 1'b1;
            ld_lane = first_set(rem_mask);
          end else begin
            s_cyc_d = 1'b0;
            ack_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (ld) begin
      lane_d  = ld_lane;
      s_cyc_d = 1'b1;
      s_adr_d = (src_adr & ~AW'(MSW - 1)) | (AW'(ld_lane) << SB);
      s_sel_d = src_sel[ld_lane*SSW +: SSW];
      s_dat_d = src_dat[ld_lane*SDW +: SDW];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      lane_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      s_cyc_q <= 1'b0;
      s_we_q  <= 1'b0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      s_sel_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      lane_q  <= lane_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      s_cyc_q <= s_cyc_d;
      s_we_q  <= s_we_d;
      s_adr_q <= s_adr_d;
      s_dat_q <= s_dat_d;
      s_sel_q <= s_sel_d;
    end
  end

  assign wbm_dat_o = rdat_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;
  assign wbm_rty_o = rty_q;
  assign wbs_adr_o = s_adr_q;
  assign wbs_dat_o = s_dat_q;
  assign wbs_sel_o = s_sel_q;
  assign wbs_we_o  = s_we_q;
  assign wbs_cyc_o = s_cyc_q;
  assign wbs_stb_o = s_cyc_q;
  assign wbs_cti_o = 3'b000;
  assign wbs_bte_o = 2'b00;
endmodule

// File: doc/peripheral_msi_data_resize_seq_wb.md
Name: peripheral_msi_data_resize_seq_wb

Overview:
Sequential Wishbone downsizer between a wide master port (MDW) and a narrow slave port (SDW).
A single master access is split into one slave access per byte-lane group that carries any selected byte.
Read data is assembled into a full MDW word, and the master receives one ack once every slave access has completed.
The block sits between a CPU/DMA master and narrow 8/16-bit peripherals in the MSI fabric.

Parameters:
- AW, 32, address width.
- MDW, 32, master data width; 16, 32 or 64.
- SDW, 8, slave data width; 8, 16 or 32; must be less than or equal to MDW.
- Derived: R = MDW/SDW slave lanes per master word; MSW = MDW/8; SSW = SDW/8; LB = log2(MSW); SB = log2(SSW).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous reset, active-high
- wbm_adr_i  in  AW  master address
- wbm_dat_i  in  MDW  master write data
- wbm_sel_i  in  MSW  master byte selects
- wbm_we_i  in  1  write enable
- wbm_cyc_i  in  1  cycle
- wbm_stb_i  in  1  strobe
- wbm_cti_i  in  3  cycle type (ignored)
- wbm_bte_i  in  2  burst type (ignored)
- wbm_dat_o  out  MDW  assembled read data
- wbm_ack_o  out  1  ack
- wbm_err_o  out  1  error
- wbm_rty_o  out  1  retry
- wbs_adr_o  out  AW  slave address
- wbs_dat_o  out  SDW  slave write data
- wbs_sel_o  out  SSW  slave byte selects
- wbs_we_o  out  1  write enable
- wbs_cyc_o  out  1  cycle
- wbs_stb_o  out  1  strobe
- wbs_cti_o  out  3  always 3'b000 (classic)
- wbs_bte_o  out  2  always 2'b00
- wbs_dat_i  in  SDW  slave read data
- wbs_ack_i  in  1  slave ack
- wbs_err_i  in  1  slave error
- wbs_rty_i  in  1  slave retry

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values:
  - All outputs are 0 and the FSM is in IDLE.
  - wbm_dat_o is 0.
  - The lane mask register is 0.
- All outputs are registered; no combinational path from master inputs to any output.
- Lane i (0..R-1) covers master bytes [i*SSW +: SSW]. A lane is active if its slice of wbm_sel_i is non-zero. Lanes are issued in ascending order.
- FSM states: IDLE, ACCESS, DONE, FAIL.
- IDLE:
  - On wbm_cyc_i & wbm_stb_i, latch adr, dat, sel and we, and build the active-lane mask.
  - If the mask is 0: go to DONE with wbm_dat_o = 0 and no slave access.
  - Otherwise: load the first active lane and go to ACCESS.
- ACCESS drive values:
  - wbs_cyc_o = wbs_stb_o = 1.
  - wbs_adr_o = {adr[AW-1:LB], lane[LB-SB-1:0], SB'b0}.
  - wbs_sel_o and wbs_dat_o are the lane slices of the latched sel and dat; wbs_we_o is the latched we.
- ACCESS on wbs_ack_i:
  - Store wbs_dat_i into lane slice of the read buffer (reads only; the buffer is cleared at request start).
  - Clear the lane's mask bit.
  - If another lane remains: advance to it; strobe stays asserted and the new address/data appear next cycle.
  - If none remains: drop wbs_cyc_o/wbs_stb_o and go to DONE.
- ACCESS on wbs_err_i or wbs_rty_i (priority err > rty > ack):
  - Drop wbs_cyc_o/wbs_stb_o; remaining lanes are abandoned.
  - Go to FAIL, carrying which of err/rty occurred.
- DONE: wbm_ack_o = 1 for exactly one cycle with the assembled wbm_dat_o, then IDLE. A new request is not sampled in the DONE cycle.
- FAIL: wbm_err_o or wbm_rty_o = 1 for exactly one cycle, then IDLE. wbm_dat_o holds the partial data.
- Master abort: if wbm_cyc_i = 0 while in ACCESS, drop the slave strobes next cycle and go to IDLE with no master response. A slave ack arriving in that same cycle is discarded.
- Latency with zero-wait slave and N active lanes: wbm_ack_o is asserted N+1 cycles after the cycle in which the request is sampled in IDLE. Slave wait states add one-for-one.
- Master bursts are handled as independent classic beats, one ack per beat.
- Reset mid-ACCESS: all outputs go to 0 the next edge; no master response is generated.

Test Plan:
1. MDW=32, SDW=8, read, sel=4'b1111, adr=0x100, slave returns 0x11,0x22,0x33,0x44 zero-wait -> slave adr 0x100,0x101,0x102,0x103 in consecutive cycles; wbm_ack_o one cycle at request+5; wbm_dat_o=0x44332211.
2. Write, sel=4'b0101, dat=0xAABBCCDD -> exactly two slave writes: adr+0 data 0xDD, adr+2 data 0xBB; one master ack.
3. MDW=32, SDW=16, read, sel=4'b0010, slave 0xBEEF -> one access at adr+0 with wbs_sel_o=2'b10; wbm_dat_o=0x0000BEEF.
4. sel=4'b1111, slave err on the second access -> third/fourth accesses not issued; wbm_err_o one cycle, no ack; next request proceeds normally.
5. sel=0 -> no slave cyc; wbm_ack_o at request+1 with data 0. Separately, rty on the first access -> wbm_rty_o one cycle.
6. wbm_cyc_i dropped during the second access with a 3-wait slave -> wbs_cyc_o low next cycle; no wbm_ack_o/err/rty. Reset asserted mid-access -> all outputs 0 next edge.
